// File: rtl/imem_boot_loader.sv
// Boot sequencer: clears IMEM, packs a little-endian byte stream into 32-bit words,
// writes them to IMEM, then releases the core after a hold-off.
module imem_boot_loader #(
    parameter int ADDR_W     = 10,
    parameter int CLR_CYCLES = 2,
    parameter int RST_HOLD   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              rst_im,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [31:0]       write_data,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4,
        S_RUN   = 3'd5
    } state_t;

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_MAX = (CLR_CYCLES > RST_HOLD) ? CLR_CYCLES : RST_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_word;
    logic [ADDR_W:0]   len_clamped;
    logic              accept;
    logic              start_ok;

    // Byte stream handshake: a byte transfers on the rising edge where s_valid and
    // s_ready are both high; s_ready is registered and only high in LOAD.
    assign accept      = s_valid && s_ready;
    assign start_ok    = start && ((state == S_IDLE) || (state == S_RUN));
    assign len_clamped = (load_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : load_len;
    assign state_dbg   = state;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_RUN: begin
                if (start) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                if (cnt == CNT_W'(CLR_CYCLES - 1))
                    state_n = (len == '0) ? S_HOLD : S_LOAD;
            end
            S_LOAD: begin
                if (accept && (byte_cnt == 2'd3)) state_n = S_WRITE;
            end
            S_WRITE: begin
                state_n = ((word_cnt + (ADDR_W+1)'(1)) == len) ? S_HOLD : S_LOAD;
            end
            S_HOLD: begin
                if (cnt == CNT_W'(RST_HOLD - 1)) state_n = S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len        <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
            s_ready    <= 1'b0;
            rst_im     <= 1'b0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_n;
            // Cycle counter restarts on every state change; only CLEAR and HOLD use it.
            cnt   <= (state_n != state) ? '0 : cnt + CNT_W'(1);

            if (start_ok) begin
                len      <= len_clamped;
                word_cnt <= '0;
                byte_cnt <= '0;
            end

            if (accept) begin
                asm_word[8*byte_cnt +: 8] <= s_data;
                byte_cnt                  <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    write_addr <= word_cnt[ADDR_W-1:0];
                    write_data <= {s_data, asm_word[23:0]};
                end
            end

            if (state == S_WRITE) word_cnt <= word_cnt + (ADDR_W+1)'(1);

            // Outputs are registered from the next state so they line up with it.
            s_ready  <= (state_n == S_LOAD);
            rst_im   <= (state_n == S_CLEAR);
            write_en <= (state_n == S_WRITE);
            core_rst <= (state_n != S_RUN);
            done     <= (state_n == S_RUN);
            busy     <= (state_n == S_CLEAR) || (state_n == S_LOAD) ||
                        (state_n == S_WRITE) || (state_n == S_HOLD);
        end
    end

endmodule
